// File: rtl/temp_pkg.sv
// Shared definitions for the temperature averaging path: FSM encoding and the
// default widths also used by the 50 MHz receive-controller bench.
package temp_pkg;

    localparam int DATA_W_DEF    = 8;
    localparam int AVG_N_DEF     = 4;
    localparam int RAM_DEPTH_DEF = 16;
    localparam int ADDR_W_DEF    = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RD   = 2'd1,
        CAP  = 2'd2,
        WR   = 2'd3
    } avg_state_t;

endpackage

// File: rtl/avg_accum.sv
// Group accumulator: running byte sum and byte counter for one averaging group.
// 'last' flags that the byte being added now completes the group.
module avg_accum
    import temp_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int AVG_N  = AVG_N_DEF
) (
    input  logic                               clk,
    input  logic                               reset_n,
    input  logic                               clr,
    input  logic                               add,
    input  logic [DATA_W-1:0]                  data,
    output logic [DATA_W+$clog2(AVG_N)-1:0]    sum,
    output logic                               last
);

    localparam int CNT_W = $clog2(AVG_N);
    localparam int SUM_W = DATA_W + CNT_W;

    logic [SUM_W-1:0] sum_q;
    logic [SUM_W-1:0] sum_d;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    // Next sum/count: clear wins over add so a finished group always restarts at zero.
    always_comb begin
        sum_d = sum_q;
        cnt_d = cnt_q;
        if (clr) begin
            sum_d = {SUM_W{1'b0}};
            cnt_d = {CNT_W{1'b0}};
        end else if (add) begin
            sum_d = sum_q + SUM_W'(data);
            cnt_d = cnt_q + CNT_W'(1);
        end else begin
            sum_d = sum_q;
            cnt_d = cnt_q;
        end
    end

    // Accumulator registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            sum_q <= {SUM_W{1'b0}};
            cnt_q <= {CNT_W{1'b0}};
        end else begin
            sum_q <= sum_d;
            cnt_q <= cnt_d;
        end
    end

    assign sum  = sum_q;
    assign last = (cnt_q == CNT_W'(AVG_N - 1));

endmodule

// File: rtl/temp_avg_ctrl.sv
// Drains temperature bytes from the receive FIFO, averages each group of AVG_N
// bytes and writes the truncated average to a wrapping address in the result RAM.
module temp_avg_ctrl
    import temp_pkg::*;
#(
    parameter int DATA_W    = DATA_W_DEF,
    parameter int AVG_N     = AVG_N_DEF,
    parameter int RAM_DEPTH = RAM_DEPTH_DEF,
    parameter int ADDR_W    = ADDR_W_DEF
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              fifo_empty,
    input  logic [DATA_W-1:0] fifo_rdata,
    output logic              fifo_rd,
    output logic              ram_wr,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [DATA_W-1:0] ram_wdata,
    output logic              ram_wrapped
);

    localparam int CNT_W = $clog2(AVG_N);
    localparam int SUM_W = DATA_W + CNT_W;

    avg_state_t        state_q;
    avg_state_t        state_d;
    logic [ADDR_W-1:0] addr_q;
    logic [ADDR_W-1:0] addr_d;
    logic              wrapped_q;
    logic              wrapped_d;
    logic [SUM_W-1:0]  sum_s;
    logic              last_s;
    logic              acc_clr_s;
    logic              acc_add_s;

    avg_accum #(
        .DATA_W (DATA_W),
        .AVG_N  (AVG_N)
    ) u_accum (
        .clk     (clk),
        .reset_n (reset_n),
        .clr     (acc_clr_s),
        .add     (acc_add_s),
        .data    (fifo_rdata),
        .sum     (sum_s),
        .last    (last_s)
    );

    // FSM state register.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next-state: fifo_empty is only consulted in IDLE, so a read in flight always completes.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (!fifo_empty) begin
                    state_d = RD;
                end else begin
                    state_d = IDLE;
                end
            end
            RD:  state_d = CAP;
            CAP: begin
                if (last_s) begin
                    state_d = WR;
                end else begin
                    state_d = IDLE;
                end
            end
            WR:      state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // FSM outputs, decoded from the present state only.
    always_comb begin
        fifo_rd   = 1'b0;
        ram_wr    = 1'b0;
        acc_add_s = 1'b0;
        acc_clr_s = 1'b0;
        case (state_q)
            IDLE: begin
                fifo_rd = 1'b0;
            end
            RD: begin
                fifo_rd = 1'b1;
            end
            CAP: begin
                acc_add_s = 1'b1;
            end
            WR: begin
                ram_wr    = 1'b1;
                acc_clr_s = 1'b1;
            end
            default: begin
                fifo_rd = 1'b0;
            end
        endcase
    end

    // Address advance after each write; the wrap flag is sticky until reset.
    always_comb begin
        addr_d    = addr_q;
        wrapped_d = wrapped_q;
        if (state_q == WR) begin
            if (addr_q == ADDR_W'(RAM_DEPTH - 1)) begin
                addr_d    = {ADDR_W{1'b0}};
                wrapped_d = 1'b1;
            end else begin
                addr_d    = addr_q + ADDR_W'(1);
                wrapped_d = wrapped_q;
            end
        end else begin
            addr_d    = addr_q;
            wrapped_d = wrapped_q;
        end
    end

    // Address and wrap-flag registers.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            addr_q    <= {ADDR_W{1'b0}};
            wrapped_q <= 1'b0;
        end else begin
            addr_q    <= addr_d;
            wrapped_q <= wrapped_d;
        end
    end

    assign ram_addr    = addr_q;
    assign ram_wrapped = wrapped_q;
    // Truncating divide by AVG_N: drop the low log2(AVG_N) bits of the registered sum.
    assign ram_wdata   = sum_s[SUM_W-1:CNT_W];

endmodule

// File: tb/tb_temp_avg_ctrl.sv
// Scoreboard bench for temp_avg_ctrl: a queue-based FIFO model feeds bytes, a group
// model predicts each RAM write, and a separate monitor checks writes as they appear.
module tb_temp_avg_ctrl;
    import temp_pkg::*;

    localparam int DATA_W    = 8;
    localparam int AVG_N     = 4;
    localparam int RAM_DEPTH = 16;
    localparam int ADDR_W    = 4;

    logic              clk        = 1'b0;
    logic              reset_n    = 1'b0;
    logic              fifo_empty = 1'b1;
    logic [DATA_W-1:0] fifo_rdata = 8'd0;
    logic              fifo_rd;
    logic              ram_wr;
    logic [ADDR_W-1:0] ram_addr;
    logic [DATA_W-1:0] ram_wdata;
    logic              ram_wrapped;

    typedef struct {
        int addr;
        int data;
        bit wrapped;
    } exp_t;

    int   n_tests     = 0;
    int   n_fail      = 0;
    int   fifo_q[$];
    int   grp[$];
    exp_t exp_q[$];
    int   wr_idx      = 0;
    int   pops        = 0;
    bit   force_empty = 1'b0;

    temp_avg_ctrl #(
        .DATA_W    (DATA_W),
        .AVG_N     (AVG_N),
        .RAM_DEPTH (RAM_DEPTH),
        .ADDR_W    (ADDR_W)
    ) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .fifo_empty  (fifo_empty),
        .fifo_rdata  (fifo_rdata),
        .fifo_rd     (fifo_rd),
        .ram_wr      (ram_wr),
        .ram_addr    (ram_addr),
        .ram_wdata   (ram_wdata),
        .ram_wrapped (ram_wrapped)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int req);
        n_tests++;
        if (act != req) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, req, $time);
        end
    endtask

    // Reference model: every AVG_N delivered bytes produce one write of floor(mean).
    task automatic model_byte(input int b);
        int   s;
        exp_t e;
        grp.push_back(b);
        if (grp.size() == AVG_N) begin
            s = 0;
            foreach (grp[i]) s += grp[i];
            e.addr    = wr_idx % RAM_DEPTH;
            e.data    = s / AVG_N;
            e.wrapped = (wr_idx >= RAM_DEPTH);
            exp_q.push_back(e);
            wr_idx++;
            grp.delete();
        end
    endtask

    // FIFO read side: data appears only in the cycle after the read strobe.
    initial begin : fifo_drv
        int v;
        forever begin
            @(negedge clk);
            if (reset_n && fifo_rd) begin
                check("rd_fifo_nonempty", int'(fifo_q.size() > 0), 1);
                fifo_rdata = 8'($urandom);
                if (fifo_q.size() > 0) begin
                    v = fifo_q.pop_front();
                    pops++;
                    @(posedge clk);
                    #1 fifo_rdata = 8'(v);
                    model_byte(v);
                    @(posedge clk);
                    #1 fifo_rdata = 8'($urandom);
                end
            end else begin
                fifo_rdata = 8'($urandom);
            end
        end
    end

    // FIFO empty flag, plus a check that no read follows an IDLE cycle that saw empty.
    initial begin : empty_drv
        bit prev_empty;
        forever begin
            @(negedge clk);
            prev_empty = fifo_empty;
            if (reset_n && fifo_rd) check("no_rd_after_empty", int'(prev_empty), 0);
            fifo_empty = force_empty || (fifo_q.size() == 0);
        end
    end

    // Monitor: every write strobe must match the oldest predicted write.
    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            if (reset_n && ram_wr) begin
                check("write_expected", int'(exp_q.size() > 0), 1);
                if (exp_q.size() > 0) begin
                    e = exp_q.pop_front();
                    check("wr_addr", int'(ram_addr), e.addr);
                    check("wr_data", int'(ram_wdata), e.data);
                    check("wr_wrapped", int'(ram_wrapped), int'(e.wrapped));
                end
            end
        end
    end

    initial begin : watchdog
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail + 1);
        $fatal(1, "watchdog expired");
    end

    task automatic do_reset();
        @(negedge clk);
        reset_n = 1'b0;
        grp.delete();
        exp_q.delete();
        wr_idx = 0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_fifo_rd", int'(fifo_rd), 0);
        check("rst_ram_wr", int'(ram_wr), 0);
        check("rst_ram_addr", int'(ram_addr), 0);
        check("rst_ram_wdata", int'(ram_wdata), 0);
        check("rst_ram_wrapped", int'(ram_wrapped), 0);
        reset_n = 1'b1;
    endtask

    task automatic push_bytes(input int b0, input int b1, input int b2, input int b3);
        fifo_q.push_back(b0);
        fifo_q.push_back(b1);
        fifo_q.push_back(b2);
        fifo_q.push_back(b3);
    endtask

    task automatic drain(input int budget, input bit rnd_empty);
        int cyc  = 0;
        bit done = 1'b0;
        while (!done && cyc < budget) begin
            @(negedge clk);
            if (rnd_empty) force_empty = ($urandom_range(0, 3) == 0);
            cyc++;
            done = (fifo_q.size() == 0) && (exp_q.size() == 0) && (grp.size() == 0);
        end
        force_empty = 1'b0;
        check("drain_in_time", int'(done), 1);
        repeat (3) @(negedge clk);
    endtask

    task automatic wait_pops(input int target, input int budget);
        int cyc = 0;
        while (pops < target && cyc < budget) begin
            @(posedge clk);
            cyc++;
        end
        check("pops_reached", int'(pops >= target), 1);
    endtask

    initial begin : stim
        int base;
        int held;

        // Reset with data already waiting, then the first group 10,20,30,40 -> 25 @ 0.
        push_bytes(10, 20, 30, 40);
        do_reset();
        check("no_rd_in_reset", pops, 0);
        drain(200, 1'b0);
        check("t2_rd_pulses", pops, 4);
        check("t2_addr_after", int'(ram_addr), 1);

        // Near-full bytes: 1019 / 4 truncates to 254 without overflow.
        push_bytes(255, 255, 255, 254);
        drain(200, 1'b0);
        check("t3_rd_pulses", pops, 8);
        check("t3_addr_after", int'(ram_addr), 2);

        // 17 groups of ones: addresses 0..15 then wrap to 0 with the sticky flag.
        do_reset();
        for (int g = 0; g < 17; g++) push_bytes(1, 1, 1, 1);
        drain(17 * 13 + 100, 1'b0);
        check("t4_wrapped", int'(ram_wrapped), 1);
        check("t4_addr_after", int'(ram_addr), 1);

        // FIFO forced empty mid-group: reads stall, then the group completes once.
        base = pops;
        fifo_q.push_back(100);
        fifo_q.push_back(7);
        wait_pops(base + 2, 100);
        force_empty = 1'b1;
        fifo_q.push_back(9);
        fifo_q.push_back(3);
        held = pops;
        repeat (20) @(negedge clk);
        check("t5_no_rd_while_empty", pops - held, 0);
        force_empty = 1'b0;
        drain(200, 1'b0);
        check("t5_rd_pulses", pops - base, 4);

        // Reset after three bytes of a group: partial sum is discarded.
        base = pops;
        fifo_q.push_back(5);
        fifo_q.push_back(6);
        fifo_q.push_back(7);
        wait_pops(base + 3, 100);
        do_reset();
        push_bytes(8, 8, 8, 8);
        drain(200, 1'b0);
        check("t6_addr_after", int'(ram_addr), 1);

        // Random groups with random empty stalls.
        for (int g = 0; g < 30; g++) begin
            push_bytes(int'($urandom_range(0, 255)), int'($urandom_range(0, 255)),
                       int'($urandom_range(0, 255)), int'($urandom_range(0, 255)));
        end
        drain(3000, 1'b1);
        check("rand_addr_after", int'(ram_addr), wr_idx % RAM_DEPTH);
        check("rand_wrapped", int'(ram_wrapped), int'(wr_idx > RAM_DEPTH - 1));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
